uart_tx_fifo: RTL and testbench

Parametrised successor to the current fixed 8N1 UART transmit path. It serialises words of configurable width with selectable parity and 1/2 stop bits. Words are buffered in an internal FIFO, so the host can queue several writes without polling Tx_BUSY per byte. It sits between the host write interface and the serial line in the uart_system top level, sharing the same baud_select encoding as the receiver.

---
 rtl/uart_tx_fifo.sv | 241 ++++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter.
// Words queue in a small FIFO and are serialised as start, DATA_W data bits
// (LSB first), optional even/odd parity and one or two stop bits. Baud rate,
// parity and stop configuration are captured when a word is popped, so
// changes made while a frame is on the line only affect the next frame.
`timescale 1ns/1ps
module uart_tx_fifo #(
  parameter int CLK_HZ     = 50000000,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [2:0]                    baud_select,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop2,
  input  logic                          Tx_EN,
  input  logic                          Tx_WR,
  input  logic [DATA_W-1:0]             Tx_DATA,
  output logic                          Tx_D,
  output logic                          Tx_BUSY,
  output logic                          Tx_FULL,
  output logic                          Tx_EMPTY,
  output logic                          Tx_OVF,
  output logic [$clog2(FIFO_DEPTH):0]   Tx_LEVEL
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int BIT_W = $clog2(DATA_W);

  localparam int DIV_300    = CLK_HZ / 300;
  localparam int DIV_1200   = CLK_HZ / 1200;
  localparam int DIV_4800   = CLK_HZ / 4800;
  localparam int DIV_9600   = CLK_HZ / 9600;
  localparam int DIV_19200  = CLK_HZ / 19200;
  localparam int DIV_38400  = CLK_HZ / 38400;
  localparam int DIV_57600  = CLK_HZ / 57600;
  localparam int DIV_115200 = CLK_HZ / 115200;

  // The slowest rate needs the widest bit-period counter.
  localparam int CNT_W = $clog2(DIV_300 + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              ovf_q, ovf_d;
  logic              fifo_full, fifo_empty;
  logic              push, pop;
  logic [DATA_W-1:0] head;

  // Transmit state machine
  state_t            state_q;
  logic              tx_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  div_m1_q;
  logic [DATA_W-1:0] shreg_q;
  logic [BIT_W-1:0]  bit_idx_q;
  logic              par_en_q;
  logic              par_bit_q;
  logic              stop2_q;
  logic              stop_second_q;

  logic [CNT_W-1:0]  div_sel;
  logic              bit_end;
  logic              par_en_sel;
  logic              par_bit_sel;

  assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);
  assign head       = mem_q[rd_ptr_q];

  // A pop only happens from IDLE; a write into a full FIFO is dropped even
  // if a pop occurs on the same edge.
  assign pop  = (state_q == S_IDLE) && Tx_EN && !fifo_empty;
  assign push = Tx_WR && Tx_EN && !fifo_full;

  assign bit_end     = (cnt_q == div_m1_q);
  assign par_en_sel  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
  assign par_bit_sel = (^head) ^ (parity_mode == 2'b10);

  // Map the baud code onto a bit period in clock cycles.
  always_comb begin
    div_sel = CNT_W'(DIV_115200);
    case (baud_select)
      3'b000:  div_sel = CNT_W'(DIV_300);
      3'b001:  div_sel = CNT_W'(DIV_1200);
      3'b010:  div_sel = CNT_W'(DIV_4800);
      3'b011:  div_sel = CNT_W'(DIV_9600);
      3'b100:  div_sel = CNT_W'(DIV_19200);
      3'b101:  div_sel = CNT_W'(DIV_38400);
      3'b110:  div_sel = CNT_W'(DIV_57600);
      3'b111:  div_sel = CNT_W'(DIV_115200);
      default: div_sel = CNT_W'(DIV_115200);
    endcase
  end

  // Next pointers, occupancy and sticky overflow for the FIFO.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop)
      level_d = level_q + LVL_W'(1);
    else if (pop && !push)
      level_d = level_q - LVL_W'(1);
    ovf_d = ovf_q;
    if (!Tx_EN)
      ovf_d = 1'b0;
    else if (Tx_WR && fifo_full)
      ovf_d = 1'b1;
  end

  // FIFO control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage; contents need no reset since occupancy governs validity.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= Tx_DATA;
  end

  // Frame sequencer: Tx_D is registered and updated on each bit boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      tx_q          <= 1'b1;
      cnt_q         <= '0;
      div_m1_q      <= '0;
      shreg_q       <= '0;
      bit_idx_q     <= '0;
      par_en_q      <= 1'b0;
      par_bit_q     <= 1'b0;
      stop2_q       <= 1'b0;
      stop_second_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q  <= 1'b1;
          cnt_q <= '0;
          if (pop) begin
            shreg_q   <= head;
            div_m1_q  <= div_sel - CNT_W'(1);
            par_en_q  <= par_en_sel;
            par_bit_q <= par_bit_sel;
            stop2_q   <= stop2;
            tx_q      <= 1'b0;
            state_q   <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            cnt_q     <= '0;
            tx_q      <= shreg_q[0];
            shreg_q   <= shreg_q >> 1;
            bit_idx_q <= '0;
            state_q   <= S_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_idx_q == BIT_W'(DATA_W - 1)) begin
              if (par_en_q) begin
                tx_q    <= par_bit_q;
                state_q <= S_PARITY;
              end else begin
                tx_q          <= 1'b1;
                stop_second_q <= 1'b0;
                state_q       <= S_STOP;
              end
            end else begin
              bit_idx_q <= bit_idx_q + BIT_W'(1);
              tx_q      <= shreg_q[0];
              shreg_q   <= shreg_q >> 1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            cnt_q         <= '0;
            tx_q          <= 1'b1;
            stop_second_q <= 1'b0;
            state_q       <= S_STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (stop2_q && !stop_second_q)
              stop_second_q <= 1'b1;
            else
              state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign Tx_D     = tx_q;
  assign Tx_BUSY  = (state_q != S_IDLE);
  assign Tx_FULL  = fifo_full;
  assign Tx_EMPTY = fifo_empty;
  assign Tx_OVF   = ovf_q;
  assign Tx_LEVEL = level_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo.
// A transaction-level model decides, per clock, which words are accepted,
// dropped or popped; popped words become expected frames that a separate
// line monitor compares bit by bit against Tx_D.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int CLK_HZ = 1152000;
  localparam int DW     = 8;
  localparam int DEPTH  = 4;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    baud_select = 3'd7;
  logic [1:0]    parity_mode = 2'b00;
  logic          stop2 = 1'b0;
  logic          tx_en = 1'b1;
  logic          tx_wr = 1'b0;
  logic [DW-1:0] tx_data = '0;

  logic          Tx_D, Tx_BUSY, Tx_FULL, Tx_EMPTY, Tx_OVF;
  logic [LW-1:0] Tx_LEVEL;

  int assertions = 0;
  int failures   = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    pm;
    logic          s2;
    logic [2:0]    code;
  } frame_t;

  frame_t        sb_q[$];
  logic [DW-1:0] m_fifo[$];
  int            m_rem = 0;
  bit            m_ovf = 1'b0;
  bit            m_full_pre, m_do_pop;
  frame_t        m_frame;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLK_HZ    (CLK_HZ),
    .DATA_W    (DW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .baud_select(baud_select),
    .parity_mode(parity_mode),
    .stop2      (stop2),
    .Tx_EN      (tx_en),
    .Tx_WR      (tx_wr),
    .Tx_DATA    (tx_data),
    .Tx_D       (Tx_D),
    .Tx_BUSY    (Tx_BUSY),
    .Tx_FULL    (Tx_FULL),
    .Tx_EMPTY   (Tx_EMPTY),
    .Tx_OVF     (Tx_OVF),
    .Tx_LEVEL   (Tx_LEVEL)
  );

  function automatic int rate_of(input logic [2:0] c);
    case (c)
      3'd0:    return 300;
      3'd1:    return 1200;
      3'd2:    return 4800;
      3'd3:    return 9600;
      3'd4:    return 19200;
      3'd5:    return 38400;
      3'd6:    return 57600;
      default: return 115200;
    endcase
  endfunction

  function automatic int div_of(input logic [2:0] c);
    return CLK_HZ / rate_of(c);
  endfunction

  function automatic int frame_bits(input frame_t f);
    int n;
    n = 1 + DW + (f.s2 ? 2 : 1);
    if (f.pm == 2'b01 || f.pm == 2'b10) n++;
    return n;
  endfunction

  task automatic check_output(input string name, input int actual, input int expected);
    assertions++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    sb_q.delete();
    m_rem = 0;
    m_ovf = 1'b0;
  endtask

  // Transaction model: decisions use the state before the edge; a frame
  // occupies the line for frame_bits*div cycles after the pop edge.
  initial forever begin
    @(posedge clk);
    if (!reset) begin
      m_full_pre = (m_fifo.size() == DEPTH);
      m_do_pop   = (m_rem == 0) && tx_en && (m_fifo.size() != 0);
      if (m_rem > 0) begin
        m_rem--;
      end else if (m_do_pop) begin
        m_frame.data = m_fifo.pop_front();
        m_frame.pm   = parity_mode;
        m_frame.s2   = stop2;
        m_frame.code = baud_select;
        m_rem = frame_bits(m_frame) * div_of(m_frame.code);
        sb_q.push_back(m_frame);
      end
      if (tx_wr && tx_en && !m_full_pre) m_fifo.push_back(tx_data);
      if (!tx_en) m_ovf = 1'b0;
      else if (tx_wr && m_full_pre) m_ovf = 1'b1;
    end
  end

  // Status outputs compared against the model every cycle.
  initial forever begin
    @(negedge clk);
    check_output("flags", int'({Tx_BUSY, Tx_FULL, Tx_EMPTY, Tx_OVF, Tx_LEVEL}),
                 int'({(m_rem > 0), (m_fifo.size() == DEPTH), (m_fifo.size() == 0),
                       m_ovf, LW'(m_fifo.size())}));
  end

  // Line monitor: on each start bit pop an expected frame and compare every
  // cycle of every bit; a reset abandons the frame in progress.
  frame_t mf;
  logic   mbits[$];
  int     mdiv, m_match, m_ones, fnum = 0;
  bit     m_abort;

  initial forever begin
    @(negedge clk);
    if (!reset && Tx_D === 1'b0) begin
      check_output("start_has_frame", int'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        mf = sb_q.pop_front();
        mdiv = div_of(mf.code);
        mbits.delete();
        mbits.push_back(1'b0);
        m_ones = 0;
        for (int i = 0; i < DW; i++) begin
          mbits.push_back(mf.data[i]);
          m_ones += int'(mf.data[i]);
        end
        if (mf.pm == 2'b01) mbits.push_back(1'(m_ones % 2));
        else if (mf.pm == 2'b10) mbits.push_back(1'((m_ones + 1) % 2));
        mbits.push_back(1'b1);
        if (mf.s2) mbits.push_back(1'b1);
        m_abort = 1'b0;
        m_match = 0;
        for (int idx = 0; idx < mbits.size() * mdiv; idx++) begin
          if (idx > 0) begin
            @(negedge clk);
            if (reset) begin
              m_abort = 1'b1;
              break;
            end
          end
          if (Tx_D === mbits[idx / mdiv]) m_match++;
          if ((idx % mdiv) == mdiv - 1) begin
            check_output($sformatf("frame%0d_bit%0d_cycles", fnum, idx / mdiv), m_match, mdiv);
            m_match = 0;
          end
        end
        if (!m_abort) begin
          @(negedge clk);
          if (!reset) check_output("idle_gap", int'(Tx_D), 1);
        end
        fnum++;
      end else begin
        for (int w = 0; w < 20000 && Tx_D === 1'b0 && !reset; w++) @(negedge clk);
      end
    end
  end

  // One clock of stimulus; called and returning 1 ns after a rising edge.
  task automatic apply_stimulus(input logic wr, input logic [DW-1:0] d);
    tx_wr   = wr;
    tx_data = d;
    @(posedge clk);
    #1;
    tx_wr = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while ((m_rem != 0 || m_fifo.size() != 0) && n < max_cycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_output("drained", int'(m_rem == 0 && m_fifo.size() == 0), 1);
    idle_cycles(3);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check_output("reset_txd", int'(Tx_D), 1);
    check_output("reset_flags", int'({Tx_BUSY, Tx_FULL, Tx_EMPTY, Tx_OVF, Tx_LEVEL}),
                 int'({1'b0, 1'b0, 1'b1, 1'b0, {LW{1'b0}}}));
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic measure_busy(input string name, input int expected);
    int n;
    n = 0;
    while (Tx_BUSY && n < 100000) begin
      n++;
      @(posedge clk);
      #1;
    end
    check_output(name, n, expected);
  endtask

  int en_hold;

  initial begin
    $display("[TB] uart_tx_fifo scoreboard bench starting");
    model_reset();
    idle_cycles(2);
    do_reset();

    // 8N1 at the fastest code: one-edge pop latency and 10-bit busy window.
    baud_select = 3'd7; parity_mode = 2'b00; stop2 = 1'b0;
    apply_stimulus(1'b1, 8'hAA);
    check_output("latency_before_fall", int'(Tx_D), 1);
    idle_cycles(1);
    check_output("latency_after_fall", int'(Tx_D), 0);
    measure_busy("busy_8n1", 10 * div_of(3'd7));
    wait_drain(1000);

    // Even parity, two stop bits.
    parity_mode = 2'b01; stop2 = 1'b1;
    apply_stimulus(1'b1, 8'h68);
    idle_cycles(1);
    measure_busy("busy_8e2", 12 * div_of(3'd7));
    wait_drain(1000);

    // Five back-to-back writes while idle fill the FIFO exactly.
    parity_mode = 2'b10; stop2 = 1'b0;
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, DW'(8'h31 + i));
    check_output("five_full", int'(Tx_FULL), 1);
    check_output("five_no_ovf", int'(Tx_OVF), 0);
    wait_drain(3000);

    // Overflow: sixth write is dropped; one disabled cycle clears the flag.
    parity_mode = 2'b00;
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, DW'(8'h11 * (i + 1)));
    apply_stimulus(1'b1, 8'hEE);
    check_output("ovf_set", int'(Tx_OVF), 1);
    check_output("ovf_level", int'(Tx_LEVEL), DEPTH);
    tx_en = 1'b0;
    idle_cycles(1);
    tx_en = 1'b1;
    check_output("ovf_cleared", int'(Tx_OVF), 0);
    wait_drain(3000);

    // Disable mid-frame with two words queued: frame finishes, queue holds.
    baud_select = 3'd6;
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, DW'(8'hC0 + i));
    idle_cycles(50);
    tx_en = 1'b0;
    for (int n = 0; n < 400 && m_rem != 0; n++) idle_cycles(1);
    idle_cycles(30);
    check_output("dis_level", int'(Tx_LEVEL), 2);
    check_output("dis_line_high", int'(Tx_D), 1);
    check_output("dis_not_busy", int'(Tx_BUSY), 0);
    tx_en = 1'b1;
    wait_drain(2000);

    // Baud sweep: check start bit and first data bit, then cut with reset.
    for (int c = 0; c < 8; c++) begin
      baud_select = 3'(c);
      parity_mode = 2'b00;
      apply_stimulus(1'b1, 8'h01);
      idle_cycles(2 * div_of(3'(c)) + 3);
      do_reset();
    end

    // Reset during data bit 3 of 0xB5 (a low bit), then a clean frame.
    baud_select = 3'd7;
    apply_stimulus(1'b1, 8'hB5);
    idle_cycles(45);
    check_output("pre_reset_low", int'(Tx_D), 0);
    do_reset();
    apply_stimulus(1'b1, 8'h3C);
    wait_drain(1000);

    // Randomised traffic, config churn and enable dropouts.
    en_hold = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(0, 99) == 0) begin
        baud_select = 3'($urandom_range(5, 7));
        parity_mode = 2'($urandom_range(0, 3));
        stop2       = 1'($urandom_range(0, 1));
      end
      if (en_hold > 0) begin
        en_hold--;
        if (en_hold == 0) tx_en = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        tx_en   = 1'b0;
        en_hold = $urandom_range(1, 60);
      end
      apply_stimulus(1'($urandom_range(0, 19) == 0), DW'($urandom));
    end
    tx_en = 1'b1;
    wait_drain(20000);
    check_output("scoreboard_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
